// File: rtl/packet_receiver.sv
// packet_receiver: byte-stream packet decoder. It turns framed host packets
// from the UART receiver into single-cycle write strobes for the tile FIFO,
// the instruction cache and the program execution queue.
module packet_receiver (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rx_interrupt,
  input  logic [7:0]   rx_data,
  output logic         mem_read_result_stb,
  output logic [287:0] mem_read_result_matrix_tile,
  output logic         upload_program_instr_stb,
  output logic [15:0]  upload_program_instr_addr,
  output logic [15:0]  upload_program_instr_dat,
  output logic         enqueue_program_stb,
  output logic [39:0]  enqueue_program_dat
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ_TILE   = 3'd1;
  localparam logic [2:0] S_UPLOAD_HDR  = 3'd2;
  localparam logic [2:0] S_UPLOAD_DATA = 3'd3;
  localparam logic [2:0] S_ENQUEUE     = 3'd4;

  localparam logic [7:0] TYPE_READ_TILE = 8'h01;
  localparam logic [7:0] TYPE_UPLOAD    = 8'h02;
  localparam logic [7:0] TYPE_ENQUEUE   = 8'h03;

  logic [2:0]   state_q, state_d;
  // Byte counter within a field; in UPLOAD_DATA bit 0 is the high/low phase.
  logic [5:0]   cnt_q, cnt_d;
  // Holds the previously received bytes of the current field. The last byte
  // of a field is combined directly from rx_data, so 35 bytes are enough.
  logic [279:0] shift_q, shift_d;
  logic [15:0]  addr_q, addr_d;
  logic [15:0]  rem_q, rem_d;

  logic         tile_stb_q, tile_stb_d;
  logic [287:0] tile_q, tile_d;
  logic         instr_stb_q, instr_stb_d;
  logic [15:0]  instr_addr_q, instr_addr_d;
  logic [15:0]  instr_dat_q, instr_dat_d;
  logic         enq_stb_q, enq_stb_d;
  logic [39:0]  enq_dat_q, enq_dat_d;

  logic [15:0]  hdr_count;
  logic [15:0]  word;

  assign hdr_count = {shift_q[7:0], rx_data};
  assign word      = {shift_q[7:0], rx_data};

  // Next-state decode: only a cycle carrying a byte advances the parser;
  // strobes fall back to zero every cycle so each lasts exactly one cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    tile_stb_d   = 1'b0;
    tile_d       = tile_q;
    instr_stb_d  = 1'b0;
    instr_addr_d = instr_addr_q;
    instr_dat_d  = instr_dat_q;
    enq_stb_d    = 1'b0;
    enq_dat_d    = enq_dat_q;

    if (rx_interrupt) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = 6'd0;
          case (rx_data)
            TYPE_READ_TILE: state_d = S_READ_TILE;
            TYPE_UPLOAD:    state_d = S_UPLOAD_HDR;
            TYPE_ENQUEUE:   state_d = S_ENQUEUE;
            default:        state_d = S_IDLE;
          endcase
        end

        S_READ_TILE: begin
          shift_d = {shift_q[271:0], rx_data};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd35) begin
            tile_d     = {shift_q, rx_data};
            tile_stb_d = 1'b1;
            cnt_d      = 6'd0;
            state_d    = S_IDLE;
          end
        end

        S_UPLOAD_HDR: begin
          shift_d = {shift_q[271:0], rx_data};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd3) begin
            addr_d  = shift_q[23:8];
            rem_d   = hdr_count;
            cnt_d   = 6'd0;
            state_d = (hdr_count == 16'd0) ? S_IDLE : S_UPLOAD_DATA;
          end
        end

        S_UPLOAD_DATA: begin
          shift_d = {shift_q[271:0], rx_data};
          if (!cnt_q[0]) begin
            cnt_d = 6'd1;
          end else begin
            cnt_d        = 6'd0;
            instr_stb_d  = 1'b1;
            instr_addr_d = addr_q;
            instr_dat_d  = word;
            addr_d       = addr_q + 16'd1;
            rem_d        = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_IDLE;
          end
        end

        S_ENQUEUE: begin
          shift_d = {shift_q[271:0], rx_data};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd4) begin
            enq_dat_d = {shift_q[31:0], rx_data};
            enq_stb_d = 1'b1;
            cnt_d     = 6'd0;
            state_d   = S_IDLE;
          end
        end

        default: begin
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset discards any partial packet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      shift_q      <= '0;
      addr_q       <= 16'd0;
      rem_q        <= 16'd0;
      tile_stb_q   <= 1'b0;
      tile_q       <= '0;
      instr_stb_q  <= 1'b0;
      instr_addr_q <= 16'd0;
      instr_dat_q  <= 16'd0;
      enq_stb_q    <= 1'b0;
      enq_dat_q    <= 40'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      tile_stb_q   <= tile_stb_d;
      tile_q       <= tile_d;
      instr_stb_q  <= instr_stb_d;
      instr_addr_q <= instr_addr_d;
      instr_dat_q  <= instr_dat_d;
      enq_stb_q    <= enq_stb_d;
      enq_dat_q    <= enq_dat_d;
    end
  end

  assign mem_read_result_stb         = tile_stb_q;
  assign mem_read_result_matrix_tile = tile_q;
  assign upload_program_instr_stb    = instr_stb_q;
  assign upload_program_instr_addr   = instr_addr_q;
  assign upload_program_instr_dat    = instr_dat_q;
  assign enqueue_program_stb         = enq_stb_q;
  assign enqueue_program_dat         = enq_dat_q;

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: scoreboard bench for packet_receiver. Expected strobe
// data is queued as the final byte of each field is driven and compared when
// the matching strobe appears; strobe timing is checked against a one-cycle
// delayed copy of the bench's own "final byte" marker.
module tb_packet_receiver;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rx_interrupt = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         mem_read_result_stb;
  logic [287:0] mem_read_result_matrix_tile;
  logic         upload_program_instr_stb;
  logic [15:0]  upload_program_instr_addr;
  logic [15:0]  upload_program_instr_dat;
  logic         enqueue_program_stb;
  logic [39:0]  enqueue_program_dat;

  packet_receiver dut (
    .clk                         (clk),
    .resetn                      (resetn),
    .rx_interrupt                (rx_interrupt),
    .rx_data                     (rx_data),
    .mem_read_result_stb         (mem_read_result_stb),
    .mem_read_result_matrix_tile (mem_read_result_matrix_tile),
    .upload_program_instr_stb    (upload_program_instr_stb),
    .upload_program_instr_addr   (upload_program_instr_addr),
    .upload_program_instr_dat    (upload_program_instr_dat),
    .enqueue_program_stb         (enqueue_program_stb),
    .enqueue_program_dat         (enqueue_program_dat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [287:0] tile_exp_q[$];
  logic [31:0]  instr_exp_q[$];
  logic [39:0]  enq_exp_q[$];
  logic [15:0]  words[$];

  // Kind of strobe the byte being driven should produce: 0 none, 1 tile,
  // 2 instr, 3 enqueue.
  int fin_kind = 0;
  int exp_kind_q = 0;

  task automatic check_eq(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference timing: a strobe is due one cycle after a final byte is sampled.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) exp_kind_q <= 0;
    else         exp_kind_q <= rx_interrupt ? fin_kind : 0;
  end

  // Monitor: strobe kind/timing every cycle, data against the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      int nst;
      int ok;
      nst = int'(mem_read_result_stb) + int'(upload_program_instr_stb) + int'(enqueue_program_stb);
      ok = (nst > 1) ? 7 : mem_read_result_stb ? 1 : upload_program_instr_stb ? 2 :
           enqueue_program_stb ? 3 : 0;
      if (ok != 0 || exp_kind_q != 0) check_eq("strobe_kind", ok, exp_kind_q);
      if (mem_read_result_stb && tile_exp_q.size() > 0) begin
        check_eq("tile_data", mem_read_result_matrix_tile, tile_exp_q.pop_front());
        $display("tile strobe: tile[287:280]=%h tile[7:0]=%h", mem_read_result_matrix_tile[287:280],
                 mem_read_result_matrix_tile[7:0]);
      end
      if (upload_program_instr_stb && instr_exp_q.size() > 0) begin
        check_eq("instr_addr_dat", {upload_program_instr_addr, upload_program_instr_dat},
                 instr_exp_q.pop_front());
        $display("instr strobe: addr=%h dat=%h", upload_program_instr_addr, upload_program_instr_dat);
      end
      if (enqueue_program_stb && enq_exp_q.size() > 0) begin
        check_eq("enq_dat", enqueue_program_dat, enq_exp_q.pop_front());
        $display("enqueue strobe: dat=%h", enqueue_program_dat);
      end
    end
  end

  // Called at a falling edge; drives one byte for one cycle after 'gap' idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, input int kind);
    repeat (gap) @(negedge clk);
    rx_interrupt = 1'b1;
    rx_data      = b;
    fin_kind     = kind;
    @(negedge clk);
    rx_interrupt = 1'b0;
    fin_kind     = 0;
  endtask

  task automatic send_tile(input logic [7:0] base);
    logic [287:0] t;
    t = '0;
    send_byte(8'h01, 0, 0);
    for (int i = 0; i < 36; i++) begin
      t = {t[279:0], 8'(base + 8'(i))};
      if (i == 35) tile_exp_q.push_back(t);
      send_byte(8'(base + 8'(i)), 0, (i == 35) ? 1 : 0);
    end
  endtask

  // Sends an upload packet using the words queue as payload.
  task automatic send_upload(input logic [15:0] start, input logic [15:0] n);
    send_byte(8'h02, 0, 0);
    send_byte(start[15:8], 0, 0);
    send_byte(start[7:0], 1, 0);
    send_byte(n[15:8], 0, 0);
    send_byte(n[7:0], 2, 0);
    for (int k = 0; k < int'(n); k++) begin
      logic [15:0] w;
      w = words[k];
      send_byte(w[15:8], k % 2, 0);
      instr_exp_q.push_back({16'(start + 16'(k)), w});
      send_byte(w[7:0], 0, 2);
    end
  endtask

  task automatic send_enq(input logic [39:0] v, input int maxgap);
    send_byte(8'h03, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 0);
    for (int i = 0; i < 5; i++) begin
      int g;
      g = (maxgap > 0 && i % 2 == 1) ? int'($urandom_range(0, maxgap)) : 0;
      if (i == 4) enq_exp_q.push_back(v);
      send_byte(v[39 - 8*i -: 8], g, (i == 4) ? 3 : 0);
    end
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any clock edge.
  task automatic async_reset_pulse();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_tile_stb", mem_read_result_stb, 0);
    check_eq("rst_tile", mem_read_result_matrix_tile, 0);
    check_eq("rst_instr_stb", upload_program_instr_stb, 0);
    check_eq("rst_instr_addr", upload_program_instr_addr, 0);
    check_eq("rst_instr_dat", upload_program_instr_dat, 0);
    check_eq("rst_enq_stb", enqueue_program_stb, 0);
    check_eq("rst_enq_dat", enqueue_program_dat, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("init_tile_stb", mem_read_result_stb, 0);
    check_eq("init_instr_stb", upload_program_instr_stb, 0);
    check_eq("init_enq_stb", enqueue_program_stb, 0);
    check_eq("init_enq_dat", enqueue_program_dat, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Tile 0x00..0x23, back-to-back bytes.
    send_tile(8'h00);
    repeat (3) @(negedge clk);

    // Upload three words at 0x0010.
    words = '{16'hAAAA, 16'h1234, 16'hBEEF};
    send_upload(16'h0010, 16'd3);
    repeat (2) @(negedge clk);

    // Asynchronous reset with nonzero outputs, then a minimal enqueue.
    async_reset_pulse();
    send_enq(40'h0000000005, 0);
    repeat (2) @(negedge clk);

    // N==0 header, immediately followed by an enqueue packet.
    words = '{};
    send_upload(16'h1234, 16'd0);
    send_enq(40'h0102030405, 0);
    repeat (2) @(negedge clk);

    // Address wrap-around.
    words = '{16'h5555, 16'h6666};
    send_upload(16'hFFFF, 16'd2);
    repeat (2) @(negedge clk);

    // Unknown type byte, then a gapped enqueue.
    send_byte(8'h7F, 0, 0);
    send_enq(40'hC0FFEE1234, 20);
    send_enq(40'hA5A5A5A5A5, 20);
    repeat (2) @(negedge clk);

    // Reset part-way through a tile packet, then an enqueue.
    send_byte(8'h01, 0, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + 8'(i)), 0, 0);
    async_reset_pulse();
    send_enq(40'h123456789A, 0);
    repeat (2) @(negedge clk);

    // Second tile with a different pattern directly after an enqueue.
    send_enq(40'hFEDCBA9876, 0);
    send_tile(8'h40);
    repeat (4) @(negedge clk);

    check_eq("tile_q_left", tile_exp_q.size(), 0);
    check_eq("instr_q_left", instr_exp_q.size(), 0);
    check_eq("enq_q_left", enq_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
